btb_sa: RTL and testbench

Parametrised set-associative Branch Target Buffer with per-entry N-bit saturating direction counters. Replaces the fully associative 8-entry BTB in the fetch stage. Adds configurable sets, ways and counter width, plus invalid-first/round-robin replacement. Adds a multi-cycle invalidate-all sweep for fence.i or context switch, with a busy handshake. Lookup is combinational from fetch PC; update arrives from branch completion.

---
 rtl/btb_sa.sv | 168 ++++++++++++++++
 tb/tb_btb_sa.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/btb_sa.sv
// rtl/btb_sa.sv - set-associative branch target buffer with saturating direction counters
// Combinational lookup, posedge update from branch completion, multi-cycle invalidate-all sweep.
module btb_sa #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int CTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc_i,
  output logic        lookup_hit_o,
  output logic        lookup_taken_o,
  output logic [31:0] lookup_target_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic [31:0] update_target_i,
  input  logic        update_taken_i,
  input  logic        update_is_branch_i,
  input  logic        inval_req_i,
  output logic        inval_busy_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   sweep_cnt_q;
  logic [WAYS-1:0]    valid_q  [SETS];
  logic [WAYS-1:0]    jump_q   [SETS];
  logic [TAG_W-1:0]   tag_q    [SETS][WAYS];
  logic [31:0]        target_q [SETS][WAYS];
  logic [CTR_W-1:0]   ctr_q    [SETS][WAYS];
  logic [WAY_W-1:0]   ptr_q    [SETS];

  logic pc_lsb_unused;
  assign pc_lsb_unused = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  // Lookup: descending scan so the lowest matching way wins.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_match;
  logic [WAY_W-1:0] lk_way;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[31:IDX_W+2];

  always_comb begin
    lk_match = 1'b0;
    lk_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_match = 1'b1;
        lk_way   = WAY_W'(w);
      end
    end
  end

  assign lookup_hit_o    = lk_match && (state_q == IDLE);
  assign lookup_taken_o  = lookup_hit_o &&
                           (jump_q[lk_idx][lk_way] || ctr_q[lk_idx][lk_way][CTR_W-1]);
  assign lookup_target_o = lookup_hit_o ? target_q[lk_idx][lk_way] : 32'h0;
  assign inval_busy_o    = (state_q == SWEEP);

  // Update way selection: hit way, else lowest invalid way, else round-robin victim.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_en;
  logic             up_hit;
  logic [WAY_W-1:0] up_hit_way;
  logic             up_inv_found;
  logic [WAY_W-1:0] up_inv_way;
  logic [WAY_W-1:0] up_way;
  logic [CTR_W-1:0] ctr_cur;
  logic [CTR_W-1:0] ctr_d;
  logic [WAY_W-1:0] ptr_d;
  logic             jump_d;

  assign up_idx = update_pc_i[IDX_W+1:2];
  assign up_tag = update_pc_i[31:IDX_W+2];
  assign up_en  = update_valid_i && (state_q == IDLE) && !inval_req_i;

  always_comb begin
    up_hit       = 1'b0;
    up_hit_way   = '0;
    up_inv_found = 1'b0;
    up_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_W'(w);
      end
      if (!valid_q[up_idx][w]) begin
        up_inv_found = 1'b1;
        up_inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    up_way  = up_hit ? up_hit_way : (up_inv_found ? up_inv_way : ptr_q[up_idx]);
    ctr_cur = ctr_q[up_idx][up_way];
    ctr_d   = ctr_cur;
    jump_d  = !update_is_branch_i;
    ptr_d   = ptr_q[up_idx];
    if (up_hit) begin
      jump_d = jump_q[up_idx][up_way] || !update_is_branch_i;
      if (update_is_branch_i) begin
        if (update_taken_i) ctr_d = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1;
        else                ctr_d = (ctr_cur == '0)      ? ctr_cur : ctr_cur - 1'b1;
      end
    end else begin
      if (!update_is_branch_i) ctr_d = CTR_MAX;
      else if (update_taken_i) ctr_d = CTR_WT;
      else                     ctr_d = CTR_WNT;
      if (!up_inv_found)
        ptr_d = (ptr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[up_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sweep_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (inval_req_i) begin
            state_q     <= SWEEP;
            sweep_cnt_q <= '0;
          end else if (up_en) begin
            valid_q[up_idx][up_way] <= 1'b1;
            ctr_q[up_idx][up_way]   <= ctr_d;
            ptr_q[up_idx]           <= ptr_d;
          end
        end
        SWEEP: begin
          valid_q[sweep_cnt_q] <= '0;
          ptr_q[sweep_cnt_q]   <= '0;
          sweep_cnt_q          <= sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == IDX_W'(SETS - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Payload fields need no reset; an invalid entry hides them.
  always_ff @(posedge clk) begin
    if (up_en) begin
      tag_q[up_idx][up_way]    <= up_tag;
      target_q[up_idx][up_way] <= update_target_i;
      jump_q[up_idx][up_way]   <= jump_d;
    end
  end

endmodule

// File: tb/tb_btb_sa.sv
// tb/tb_btb_sa.sv - directed self-checking bench for btb_sa
module tb_btb_sa;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc_i;
  logic        lookup_hit_o;
  logic        lookup_taken_o;
  logic [31:0] lookup_target_o;
  logic        update_valid_i;
  logic [31:0] update_pc_i;
  logic [31:0] update_target_i;
  logic        update_taken_i;
  logic        update_is_branch_i;
  logic        inval_req_i;
  logic        inval_busy_o;

  int vecs = 0;
  int errs = 0;
  int n;

  btb_sa #(.SETS(16), .WAYS(2), .CTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .lookup_pc_i(lookup_pc_i), .lookup_hit_o(lookup_hit_o),
    .lookup_taken_o(lookup_taken_o), .lookup_target_o(lookup_target_o),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_target_i(update_target_i), .update_taken_i(update_taken_i),
    .update_is_branch_i(update_is_branch_i),
    .inval_req_i(inval_req_i), .inval_busy_o(inval_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] pc, input logic eh,
                     input logic et, input logic [31:0] etg);
    lookup_pc_i = pc;
    #1;
    vecs++;
    assert ({lookup_hit_o, lookup_taken_o, lookup_target_o} === {eh, et, etg}) else begin
      errs++;
      $error("FAIL %s: hit/taken/target got %0b/%0b/%h exp %0b/%0b/%h", name,
             lookup_hit_o, lookup_taken_o, lookup_target_o, eh, et, etg);
    end
  endtask

  task automatic chk_busy(input string name, input logic eb);
    vecs++;
    assert (inval_busy_o === eb) else begin
      errs++;
      $error("FAIL %s: busy got %0b exp %0b", name, inval_busy_o, eb);
    end
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic br);
    update_valid_i     = 1'b1;
    update_pc_i        = pc;
    update_target_i    = tgt;
    update_taken_i     = tk;
    update_is_branch_i = br;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk, input logic br);
    drive_upd(pc, tgt, tk, br);
    @(posedge clk); #1;
    update_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_inval();
    inval_req_i = 1'b1;
    @(posedge clk); #1;
    inval_req_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lookup_pc_i = 32'h100; inval_req_i = 1'b0;
    update_valid_i = 1'b0; update_pc_i = '0; update_target_i = '0;
    update_taken_i = 1'b0; update_is_branch_i = 1'b0;
    chk("reset_lookup", 32'h100, 0, 0, 32'h0);
    chk_busy("reset_busy", 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: branch insert; same-cycle lookup still sees old state
    drive_upd(32'h100, 32'h200, 1, 1);
    chk("t1_same_cycle", 32'h100, 0, 0, 32'h0);
    @(posedge clk); #1;
    update_valid_i = 1'b0;
    chk("t1_hit", 32'h100, 1, 1, 32'h200);
    chk("t1_miss_104", 32'h104, 0, 0, 32'h0);

    // 2: counter saturation at both ends
    upd(32'h100, 32'h200, 0, 1); chk("t2_nt1", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h200, 0, 1); chk("t2_nt2", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h200, 0, 1); chk("t2_nt3", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h200, 1, 1); chk("t2_t1",  32'h100, 1, 0, 32'h200);
    upd(32'h100, 32'h200, 1, 1); chk("t2_t2",  32'h100, 1, 1, 32'h200);
    upd(32'h100, 32'h200, 1, 1);
    upd(32'h100, 32'h200, 1, 1);
    upd(32'h100, 32'h200, 0, 1); chk("t2_top_sat", 32'h100, 1, 1, 32'h200);
    upd(32'h100, 32'h204, 0, 1); chk("t2_dec_tgt", 32'h100, 1, 0, 32'h204);

    // 3: invalid-first then round-robin replacement in set 0
    do_reset();
    upd(32'h100, 32'h1000, 1, 1);
    upd(32'h140, 32'h1400, 1, 1);
    upd(32'h180, 32'h1800, 1, 1);
    chk("t3_100_evicted", 32'h100, 0, 0, 32'h0);
    chk("t3_140_hit",     32'h140, 1, 1, 32'h1400);
    chk("t3_180_hit",     32'h180, 1, 1, 32'h1800);
    upd(32'h1C0, 32'h1C00, 1, 1);
    chk("t3_140_evicted", 32'h140, 0, 0, 32'h0);
    chk("t3_1c0_hit",     32'h1C0, 1, 1, 32'h1C00);
    chk("t3_180_kept",    32'h180, 1, 1, 32'h1800);
    upd(32'h200, 32'h2000, 1, 1);
    chk("t3_wrap_180_evicted", 32'h180, 0, 0, 32'h0);
    chk("t3_wrap_1c0_kept",    32'h1C0, 1, 1, 32'h1C00);

    // 4: jumps stay taken; not-taken branch inserts weakly not-taken
    do_reset();
    upd(32'h300, 32'h80, 1, 0);
    chk("t4_jump_ins", 32'h300, 1, 1, 32'h80);
    upd(32'h300, 32'h80, 0, 0);
    chk("t4_jump_nt", 32'h300, 1, 1, 32'h80);
    upd(32'h304, 32'h90, 0, 1);
    chk("t4_br_wnt", 32'h304, 1, 0, 32'h90);
    upd(32'h304, 32'h90, 1, 1);
    chk("t4_br_wt", 32'h304, 1, 1, 32'h90);

    // 5: invalidate sweep with dropped updates and an ignored re-request
    do_reset();
    upd(32'h100, 32'h10, 1, 1);
    upd(32'h104, 32'h14, 1, 1);
    upd(32'h108, 32'h18, 1, 0);
    upd(32'h13C, 32'h1C, 1, 1);
    chk("t5_pre_13c", 32'h13C, 1, 1, 32'h1C);
    drive_upd(32'h600, 32'h60, 1, 0);
    pulse_inval();
    update_valid_i = 1'b0;
    n = 0;
    while (inval_busy_o && n < 40) begin
      n++;
      if (n == 1) drive_upd(32'h500, 32'h50, 1, 0);
      if (n == 2) update_valid_i = 1'b0;
      inval_req_i = (n == 3);
      chk($sformatf("t5_sweep_miss_%0d", n), 32'h13C, 0, 0, 32'h0);
      @(posedge clk); #1;
    end
    inval_req_i = 1'b0;
    vecs++;
    assert (n == 16) else begin
      errs++;
      $error("FAIL t5_busy_len: busy cycles got %0d exp 16", n);
    end
    chk("t5_after_100", 32'h100, 0, 0, 32'h0);
    chk("t5_after_104", 32'h104, 0, 0, 32'h0);
    chk("t5_after_108", 32'h108, 0, 0, 32'h0);
    chk("t5_after_13c", 32'h13C, 0, 0, 32'h0);
    chk("t5_after_500", 32'h500, 0, 0, 32'h0);
    chk("t5_after_600", 32'h600, 0, 0, 32'h0);

    // 6: asynchronous reset in the middle of a sweep
    upd(32'h100, 32'h10, 1, 1);
    upd(32'h140, 32'h14, 1, 1);
    upd(32'h13C, 32'h1C, 1, 1);
    pulse_inval();
    repeat (5) begin @(posedge clk); #1; end
    chk_busy("t6_busy_before_rst", 1);
    #2;
    rst = 1'b1;
    #1;
    chk_busy("t6_busy_async", 0);
    chk("t6_outputs_async", 32'h13C, 0, 0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_busy("t6_busy_after", 0);
    chk("t6_100_miss", 32'h100, 0, 0, 32'h0);
    chk("t6_140_miss", 32'h140, 0, 0, 32'h0);
    chk("t6_13c_miss", 32'h13C, 0, 0, 32'h0);
    upd(32'h180, 32'h18, 1, 1);
    upd(32'h1C0, 32'h1C, 1, 1);
    upd(32'h200, 32'h20, 1, 1);
    chk("t6_way0_evicted", 32'h180, 0, 0, 32'h0);
    chk("t6_way1_kept",    32'h1C0, 1, 1, 32'h1C);
    chk("t6_new_hit",      32'h200, 1, 1, 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
